// File: rtl/gray_count_ctrl.sv
// Run/pause/step controller and rate scheduler for a Gray-code counter.
// Every register is on clk; the count advances only on single-cycle divider ticks.
module gray_count_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DIV_W    = 27,
  parameter int unsigned BASE_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             dir_sw,
  input  logic [1:0]       rate_sel,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic               run_s1_q, run_s2_q, run_s3_q;
  logic               step_s1_q, step_s2_q, step_s3_q;
  logic               dir_s1_q, dir_s2_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [WIDTH-1:0]   gray_q, gray_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;

  logic               run_p, step_p;
  logic [DIV_W-1:0]   limit_m1;
  logic               terminal;
  logic               adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      run_s3_q  <= 1'b0;
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
      dir_s1_q  <= 1'b0;
      dir_s2_q  <= 1'b0;
      div_q     <= '0;
      bin_q     <= '0;
      gray_q    <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_s1_q  <= btn_run;
      run_s2_q  <= run_s1_q;
      run_s3_q  <= run_s2_q;
      step_s1_q <= btn_step;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
      dir_s1_q  <= dir_sw;
      dir_s2_q  <= dir_s1_q;
      div_q     <= div_d;
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  // ">=" rather than "==" so a switch to a faster rate never waits for a full counter wrap
  always_comb begin
    run_p    = run_s2_q & ~run_s3_q;
    step_p   = step_s2_q & ~step_s3_q;
    limit_m1 = (DIV_W'(BASE_DIV) >> rate_sel) - DIV_W'(1);
    terminal = (div_q >= limit_m1);

    state_d = state_q;
    div_d   = div_q;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (run_p) begin
          state_d = RUN;
        end else if (step_p) begin
          state_d = PAUSE;
          adv     = 1'b1;
        end
      end
      RUN: begin
        if (terminal) begin
          div_d = '0;
          adv   = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (run_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (run_p) begin
          state_d = RUN;
        end else if (step_p) begin
          adv = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (adv) begin
      bin_d  = dir_s2_q ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
      gray_d = bin_d ^ (bin_d >> 1);
      tick_d = 1'b1;
      wrap_d = dir_s2_q ? (&bin_q) : ~(|bin_q);
    end
  end

  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Randomised and directed bench for gray_count_ctrl against a cycle-level behavioural model.
module tb_gray_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       dir_sw = 1'b1;
  logic [1:0] rate_sel = 2'd0;
  logic [3:0] bin_out, gray_out;
  logic       tick, wrap;
  logic [1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_count_ctrl #(.WIDTH(4), .DIV_W(27), .BASE_DIV(8)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .dir_sw(dir_sw), .rate_sel(rate_sel), .bin_out(bin_out),
    .gray_out(gray_out), .tick(tick), .wrap(wrap), .state_out(state_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 pause. h*[i] = raw input sampled i+1 edges ago.
  int m_mode = 0, m_div = 0, m_bin = 0;
  bit m_tick = 0, m_wrap = 0;
  bit hr[3], hs[3], hd[3];

  always @(posedge clk) begin : model
    bit rp, sp, up, adv;
    int lim;
    if (rst) begin
      m_mode = 0; m_div = 0; m_bin = 0; m_tick = 0; m_wrap = 0;
      for (int i = 0; i < 3; i++) begin hr[i] = 0; hs[i] = 0; hd[i] = 0; end
    end else begin
      rp  = hr[1] && !hr[2];
      sp  = hs[1] && !hs[2];
      up  = hd[1];
      adv = 0;
      lim = 8 >> rate_sel;
      if (m_mode == 0) begin
        if (rp) m_mode = 1;
        else if (sp) begin m_mode = 2; adv = 1; end
      end else if (m_mode == 1) begin
        if (m_div >= lim - 1) begin m_div = 0; adv = 1; end
        else m_div = m_div + 1;
        if (rp) m_mode = 2;
      end else begin
        if (rp) m_mode = 1;
        else if (sp) adv = 1;
      end
      m_tick = adv;
      m_wrap = 0;
      if (adv) begin
        if (up) begin m_wrap = (m_bin == 15); m_bin = (m_bin + 1) % 16; end
        else    begin m_wrap = (m_bin == 0);  m_bin = (m_bin + 15) % 16; end
      end
      hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = btn_run;
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = btn_step;
      hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = dir_sw;
    end
  end

  always @(negedge clk) begin
    check("bin",   int'(bin_out),   m_bin);
    check("gray",  int'(gray_out),  m_bin ^ (m_bin >> 1));
    check("tick",  int'(tick),      int'(m_tick));
    check("wrap",  int'(wrap),      int'(m_wrap));
    check("state", int'(state_out), m_mode);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_run(input int hold);
    btn_run = 1'b1; cyc(hold); btn_run = 1'b0; cyc(1);
  endtask

  task automatic press_step(input int hold);
    btn_step = 1'b1; cyc(hold); btn_step = 1'b0; cyc(1);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (tick) seen = 1;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; cyc(n); rst = 1'b0;
  endtask

  initial begin
    logic [3:0] gray_tab [3];
    gray_tab[0] = 4'b0001; gray_tab[1] = 4'b0011; gray_tab[2] = 4'b0010;

    cyc(3); rst = 1'b0; cyc(20);
    check("rst_bin", int'(bin_out), 0);
    check("rst_state", int'(state_out), 0);

    // Up count through a full wrap
    dir_sw = 1'b1; rate_sel = 2'd0;
    press_run(3);
    check("run_state", int'(state_out), 1);
    for (int i = 1; i <= 16; i++) begin
      wait_tick();
      if (i <= 3) check("gray_seq", int'(gray_out), int'(gray_tab[i-1]));
      if (i == 16) begin
        check("wrap16_bin", int'(bin_out), 0);
        check("wrap16_wrap", int'(wrap), 1);
      end
    end

    // Pause, step, resume, step while running
    cyc(3);
    press_run(2);
    cyc(50);
    check("pause_state", int'(state_out), 2);
    press_step(4);
    cyc(10);
    press_run(2);
    cyc(5);
    press_step(3);
    cyc(20);

    // Faster rate while divider is past the new limit
    wait_tick();
    cyc(5);
    rate_sel = 2'd3;
    cyc(1);
    check("rate_tick1", int'(tick), 1);
    cyc(1);
    check("rate_tick2", int'(tick), 1);
    rate_sel = 2'd0;
    cyc(10);

    // run and step together in IDLE
    do_reset(2);
    cyc(3);
    btn_run = 1'b1; btn_step = 1'b1; cyc(3);
    btn_run = 1'b0; btn_step = 1'b0; cyc(1);
    check("both_state", int'(state_out), 1);
    check("both_bin", int'(bin_out), 0);

    // Reset mid-run at bin 9
    for (int i = 0; i < 200 && m_bin != 9; i++) cyc(1);
    check("reach9", m_bin, 9);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("midrst_bin", int'(bin_out), 0);
    check("midrst_gray", int'(gray_out), 0);
    check("midrst_state", int'(state_out), 0);

    // Down wrap from reset
    dir_sw = 1'b0; cyc(3);
    press_run(2);
    wait_tick();
    check("down_bin", int'(bin_out), 15);
    check("down_gray", int'(gray_out), 8);
    check("down_wrap", int'(wrap), 1);
    wait_tick();
    check("down2_bin", int'(bin_out), 14);
    check("down2_gray", int'(gray_out), 9);
    check("down2_wrap", int'(wrap), 0);

    // Button held through reset gives exactly one pulse
    btn_run = 1'b1;
    do_reset(3);
    cyc(10);
    check("held_state", int'(state_out), 1);
    btn_run = 1'b0;
    cyc(5);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) btn_run  = ~btn_run;
      if ($urandom_range(0, 9) == 0)  btn_step = ~btn_step;
      if ($urandom_range(0, 49) == 0) dir_sw   = ~dir_sw;
      if ($urandom_range(0, 39) == 0) rate_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_count_ctrl.md
Name: gray_count_ctrl

Overview:
Run/pause/step controller and rate scheduler for the lab's Gray-code counter.
- Replaces the divided-clock approach. All logic runs on the board clock.
- The counter advances only on single-cycle enable ticks from an internal programmable divider.
- Board button and switch inputs are synchronised and edge-detected internally.
- A small state machine decides when the count advances. Outputs drive LEDs directly.

Parameters:
WIDTH, 4, counter width in bits (bin_out / gray_out).
DIV_W, 27, divider counter width.
BASE_DIV, 50000000, tick period in clk cycles at rate_sel=0. Must be >= 8 and < 2^DIV_W.

Ports:
clk  in  1  board clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
btn_run  in  1  raw run/pause button, asynchronous level.
btn_step  in  1  raw single-step button, asynchronous level.
dir_sw  in  1  raw direction switch; 1=up, 0=down.
rate_sel  in  2  rate select; tick period = BASE_DIV >> rate_sel.
bin_out  out  WIDTH  binary count.
gray_out  out  WIDTH  Gray code of bin_out, registered and aligned with bin_out.
tick  out  1  one-cycle pulse each time the count advances.
wrap  out  1  one-cycle pulse, coincident with tick, when count wraps.
state_out  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. rst clears every register, including synchronisers and edge detectors, on the next edge.
- Reset values: bin_out=0, gray_out=0, tick=0, wrap=0, state_out=00, divider=0.
- Reset priority: rst overrides all other inputs, including mid-RUN. Outputs show reset values after the edge where rst=1.
- Input conditioning:
  - Two-flop synchroniser on btn_run, btn_step and dir_sw.
  - Rising-edge detect on synced btn_run/btn_step gives run_p/step_p, each exactly one clk wide.
  - Latency: a button first sampled high at edge k gives a pulse active in the cycle after edge k+1.
  - A button held through reset produces one pulse after rst deasserts.
  - Holding a button never repeats the pulse.
- Divider:
  - Limit L = BASE_DIV >> rate_sel.
  - In RUN, div_cnt increments each cycle. When div_cnt >= L-1, div_cnt <= 0 and an advance occurs.
  - The >= compare covers rate_sel changing to a faster rate while div_cnt is already past the new L-1: advance on the next cycle, no long wrap.
  - In IDLE, div_cnt is held at 0. In PAUSE, div_cnt holds its value, and RUN resumes from that value.
- Advance: one registered edge updates all of the following together:
  - bin <= bin+1 (dir=1) or bin-1 (dir=0), modulo 2^WIDTH, using the synced direction.
  - gray_out <= next_bin ^ (next_bin >> 1).
  - tick <= 1.
  - wrap <= 1 if bin goes max->0 (up) or 0->max (down).
  - tick and wrap are 0 in every cycle without an advance.
- FSM transitions:
  - IDLE: run_p -> RUN. step_p -> PAUSE plus one advance.
  - RUN: run_p -> PAUSE. step_p is ignored.
  - PAUSE: run_p -> RUN. step_p gives one advance, and the state stays PAUSE.
- Simultaneous events:
  - run_p and step_p in the same cycle: run_p wins and step_p is dropped.
  - run_p in the same cycle as a RUN terminal count: the advance still occurs, then the state is PAUSE with div_cnt=0.
- Direction change takes effect on the next advance. No advance is generated by the change itself.

Test Plan (BASE_DIV=8, WIDTH=4):
- Reset: rst high 3 cycles, then 20 idle cycles -> all outputs 0, state_out=00, no tick.
- Run up counting: dir_sw=1, rate_sel=0, pulse btn_run.
  - state_out=01; tick every 8 cycles.
  - gray_out sequence 0001, 0011, 0010, 0110, 0111, ...
  - 16th tick: bin_out=0, gray_out=0000, wrap=1.
- Down wrap: from reset, dir_sw=0, run.
  - First tick: bin_out=15, gray_out=1000, wrap=1.
  - Next tick: bin_out=14, gray_out=1001, wrap=0.
- Pause and step:
  - run_p in RUN -> state 10 and count frozen for 50 cycles.
  - step -> exactly one tick, bin +1.
  - run -> divider resumes from its held value.
  - step in RUN -> no extra tick.
- Rate change: in RUN at rate_sel=0 with div_cnt=5, switch rate_sel to 3 (L=1) -> tick next cycle, then every cycle.
- Edge cases:
  - run and step pressed the same cycle in IDLE -> RUN, no advance.
  - rst asserted mid-RUN at bin=9 -> next cycle all outputs 0, state 00.
